// File: rtl/intel_vip_reset_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : intel_vip_reset_gen_sequencer
// Purpose  : Ordered reset-release controller. It releases each stage in turn,
//            waits for that stage's ready, flags timeouts and re-sequences
//            when a confirmed stage loses ready.
// Revision : 1.0 - initial release
// ============================================================================
module intel_vip_reset_gen_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGE_DELAY    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int c_IDX_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic                  fault,
  output logic [c_IDX_W-1:0]    fault_stage
);

  localparam int c_CNT_MAX = (HOLD_CYCLES > STAGE_DELAY)
                           ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
                           : ((STAGE_DELAY > TIMEOUT_CYCLES) ? STAGE_DELAY : TIMEOUT_CYCLES);
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DELAY_LAST = c_CNT_W'(STAGE_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_STAGES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);

  localparam logic [2:0] c_ST_ASSERT = 3'd0;
  localparam logic [2:0] c_ST_HOLD   = 3'd1;
  localparam logic [2:0] c_ST_WAIT   = 3'd2;
  localparam logic [2:0] c_ST_DELAY  = 3'd3;
  localparam logic [2:0] c_ST_RUN    = 3'd4;
  localparam logic [2:0] c_ST_FAULT  = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic [NUM_STAGES-1:0] w_confirmed;
  logic [NUM_STAGES-1:0] w_stage_reset_nxt;
  logic                  w_lost;
  logic                  w_ready_cur;
  logic                  w_released;
  logic                  w_all_released_nxt;
  logic                  w_fault_nxt;
  logic [c_IDX_W-1:0]    w_fault_stage_nxt;

  // Stages already confirmed ready; the stage currently awaited is excluded.
  always_comb begin
    w_confirmed = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      w_confirmed[j] = (r_state == c_ST_RUN) ||
                       (((r_state == c_ST_WAIT) || (r_state == c_ST_DELAY)) &&
                        (c_IDX_W'(j) < r_idx));
    end
  end

  assign w_lost      = |(w_confirmed & ~stage_ready);
  assign w_ready_cur = stage_ready[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_ST_ASSERT;
      r_idx        <= '0;
      r_count      <= '0;
      stage_reset  <= '1;
      all_released <= 1'b0;
      fault        <= 1'b0;
      fault_stage  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_count      <= w_count_nxt;
      stage_reset  <= w_stage_reset_nxt;
      all_released <= w_all_released_nxt;
      fault        <= w_fault_nxt;
      fault_stage  <= w_fault_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    if (sw_reset_req) begin
      w_state_nxt = c_ST_ASSERT;
      w_idx_nxt   = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        c_ST_ASSERT: begin
          w_state_nxt = c_ST_HOLD;
          w_idx_nxt   = '0;
          w_count_nxt = '0;
        end
        c_ST_HOLD: begin
          if (r_count == c_HOLD_LAST) begin
            w_state_nxt = c_ST_WAIT;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + c_CNT_ONE;
          end
        end
        c_ST_WAIT: begin
          if (w_lost) begin
            w_state_nxt = c_ST_ASSERT;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
          end else if (w_ready_cur) begin
            w_state_nxt = (r_idx == c_IDX_LAST) ? c_ST_RUN : c_ST_DELAY;
            w_count_nxt = '0;
          end else if (r_count == c_TO_LAST) begin
            w_state_nxt = c_ST_FAULT;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + c_CNT_ONE;
          end
        end
        c_ST_DELAY: begin
          if (w_lost) begin
            w_state_nxt = c_ST_ASSERT;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
          end else if (r_count == c_DELAY_LAST) begin
            w_state_nxt = c_ST_WAIT;
            w_idx_nxt   = r_idx + c_IDX_ONE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + c_CNT_ONE;
          end
        end
        c_ST_RUN: begin
          if (w_lost) begin
            w_state_nxt = c_ST_ASSERT;
            w_idx_nxt   = '0;
            w_count_nxt = '0;
          end
        end
        c_ST_FAULT: begin
          w_state_nxt = c_ST_FAULT;
        end
        default: begin
          w_state_nxt = c_ST_ASSERT;
          w_idx_nxt   = '0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_released = (w_state_nxt == c_ST_WAIT) || (w_state_nxt == c_ST_DELAY) ||
                 (w_state_nxt == c_ST_RUN);
    w_stage_reset_nxt = '1;
    for (int j = 0; j < NUM_STAGES; j++) begin
      w_stage_reset_nxt[j] = !(w_released && (c_IDX_W'(j) <= w_idx_nxt));
    end
    w_all_released_nxt = (w_state_nxt == c_ST_RUN);
    w_fault_nxt        = (w_state_nxt == c_ST_FAULT) ||
                         (fault && (w_state_nxt == c_ST_ASSERT));
    w_fault_stage_nxt  = ((w_state_nxt == c_ST_FAULT) && (r_state != c_ST_FAULT))
                       ? r_idx : fault_stage;
  end

endmodule
`default_nettype wire

// File: tb/tb_intel_vip_reset_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_intel_vip_reset_gen_sequencer
// Purpose  : Scoreboarded bench for the reset-release sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intel_vip_reset_gen_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int SD   = 8;
  localparam int TO   = 1024;
  localparam int FSW  = 2;

  localparam int P_ASSERT = 0;
  localparam int P_HOLD   = 1;
  localparam int P_WAIT   = 2;
  localparam int P_DELAY  = 3;
  localparam int P_RUN    = 4;
  localparam int P_FAULT  = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           sw_reset_req;
  logic [N-1:0]   stage_ready;
  logic [N-1:0]   stage_reset;
  logic           all_released;
  logic           fault;
  logic [FSW-1:0] fault_stage;

  intel_vip_reset_gen_sequencer #(
    .NUM_STAGES    (N),
    .HOLD_CYCLES   (HOLD),
    .STAGE_DELAY   (SD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_reset_req (sw_reset_req),
    .stage_ready  (stage_ready),
    .stage_reset  (stage_reset),
    .all_released (all_released),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   sr;
    logic           ar;
    logic           f;
    logic [FSW-1:0] fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ecount   = 0;

  // Reference model: phase, number of released stages, edges spent in phase.
  int   m_phase  = P_ASSERT;
  int   m_nrel   = 0;
  int   m_t      = 0;
  int   m_fstage = 0;
  bit   m_fault  = 0;

  logic [N-1:0] force_lo = '0;
  logic [N-1:0] force_hi = '0;
  int           dly[N];
  logic [N-1:0] hist[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, ecount);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event not seen within bound (edge %0d)", name, ecount);
  endtask

  task automatic model_step(input logic rst, input logic sw, input logic [N-1:0] rdy);
    int cur;
    bit lost;
    lost = 0;
    if (rst) begin
      m_phase = P_ASSERT; m_nrel = 0; m_t = 0; m_fault = 0; m_fstage = 0;
    end else if (sw) begin
      m_phase = P_ASSERT; m_nrel = 0; m_t = 0;
    end else begin
      case (m_phase)
        P_ASSERT: begin m_phase = P_HOLD; m_t = 0; m_fault = 0; end
        P_HOLD: begin
          m_t++;
          if (m_t == HOLD) begin m_phase = P_WAIT; m_nrel = 1; m_t = 0; end
        end
        P_WAIT: begin
          cur = m_nrel - 1;
          for (int j = 0; j < cur; j++) if (!rdy[j]) lost = 1;
          if (lost) begin
            m_phase = P_ASSERT; m_nrel = 0; m_t = 0;
          end else if (rdy[cur]) begin
            if (m_nrel == N) m_phase = P_RUN;
            else begin m_phase = P_DELAY; m_t = 0; end
          end else begin
            m_t++;
            if (m_t == TO) begin m_phase = P_FAULT; m_fault = 1; m_fstage = cur; end
          end
        end
        P_DELAY: begin
          for (int j = 0; j < m_nrel - 1; j++) if (!rdy[j]) lost = 1;
          if (lost) begin
            m_phase = P_ASSERT; m_nrel = 0; m_t = 0;
          end else begin
            m_t++;
            if (m_t == SD) begin m_phase = P_WAIT; m_nrel++; m_t = 0; end
          end
        end
        P_RUN: begin
          for (int j = 0; j < N; j++) if (!rdy[j]) lost = 1;
          if (lost) begin m_phase = P_ASSERT; m_nrel = 0; m_t = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   mask;
    mask = (1 << m_nrel) - 1;
    e.sr = (m_phase == P_WAIT || m_phase == P_DELAY || m_phase == P_RUN)
         ? N'(~mask) : {N{1'b1}};
    e.ar = (m_phase == P_RUN);
    e.f  = m_fault;
    e.fs = FSW'(m_fstage);
    return e;
  endfunction

  // Stimulus side of the scoreboard: model steps on the same edge the DUT does.
  initial begin
    forever begin
      @(posedge clk);
      ecount++;
      model_step(reset, sw_reset_req, stage_ready);
      exp_q.push_back(model_out());
    end
  end

  // Monitor: registered outputs are compared half a cycle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_stage_reset", 32'(stage_reset), 32'(e.sr));
        chk("sb_all_released", 32'(all_released), 32'(e.ar));
        chk("sb_fault", 32'(fault), 32'(e.f));
        chk("sb_fault_stage", 32'(fault_stage), 32'(e.fs));
      end
    end
  end

  // Plant: each stage reports ready dly[j] cycles after its reset is released.
  initial begin
    stage_ready = '0;
    for (int k = 0; k < 64; k++) hist[k] = '0;
    forever begin
      @(negedge clk);
      #1;
      hist[ecount % 64] = ~stage_reset;
      for (int j = 0; j < N; j++)
        stage_ready[j] = force_hi[j] | (~force_lo[j] & hist[(ecount - dly[j] + 64) % 64][j]);
    end
  end

  task automatic wait_fall(input int b, input int exp_edge, input string name, output int edge_o);
    bit seen;
    seen = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (stage_reset[b] === 1'b0) seen = 1;
    end
    edge_o = ecount;
    if (!seen) bound_fail(name);
    else if (exp_edge >= 0) chk(name, ecount, exp_edge);
  endtask

  task automatic wait_out(input int which, input int exp_edge, input string name, output int edge_o);
    bit seen;
    seen = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (((which == 0) ? all_released : fault) === 1'b1) seen = 1;
    end
    edge_o = ecount;
    if (!seen) bound_fail(name);
    else if (exp_edge >= 0) chk(name, ecount, exp_edge);
  endtask

  task automatic sw_pulse(output int edge_o);
    sw_reset_req = 1'b1;
    edge_o = ecount + 1;
    @(negedge clk);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (edge %0d)", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, f, s, p, l, r, drop_left;
    reset = 1'b1;
    sw_reset_req = 1'b0;
    for (int j = 0; j < N; j++) dly[j] = 3;
    repeat (3) @(negedge clk);
    chk("rst_stage_reset", 32'(stage_reset), 32'hF);
    chk("rst_all_released", 32'(all_released), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_stage", 32'(fault_stage), 32'h0);

    // Nominal release order and spacing
    reset = 1'b0;
    e0 = ecount + 1;
    for (int i = 0; i < N; i++) wait_fall(i, e0 + HOLD + i * (4 + SD), "t1_fall", f);
    wait_out(0, f + 4, "t1_all_released", f);
    chk("t1_fault", 32'(fault), 32'h0);
    repeat (10) @(negedge clk);

    // Loss of ready in RUN, then reset during DELAY of the re-sequence
    force_lo = 4'b0001;
    l = ecount + 1;
    @(negedge clk);
    force_lo = '0;
    chk("t4_stage_reset", 32'(stage_reset), 32'hF);
    chk("t4_all_released", 32'(all_released), 32'h0);
    chk("t4_fault", 32'(fault), 32'h0);
    wait_fall(0, l + 1 + HOLD, "t4_fall0", f);
    wait_fall(1, f + 4 + SD, "t5_fall1", f);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_stage_reset", 32'(stage_reset), 32'hF);
    chk("t5_all_released", 32'(all_released), 32'h0);
    chk("t5_fault", 32'(fault), 32'h0);
    e0 = ecount + 1;
    wait_fall(0, e0 + HOLD, "t5_fall0", f);
    wait_out(0, -1, "t5_done", f);

    // Timeout on stage 2, sticky fault, restart
    force_lo = 4'b0100;
    sw_pulse(s);
    wait_fall(0, s + 1 + HOLD, "t2_fall0", f);
    wait_fall(1, f + 4 + SD, "t2_fall1", f);
    wait_fall(2, f + 4 + SD, "t2_fall2", f);
    wait_out(1, f + TO, "t2_fault_edge", f);
    chk("t2_fault_stage", 32'(fault_stage), 32'h2);
    chk("t2_stage_reset", 32'(stage_reset), 32'hF);
    repeat (5000) @(negedge clk);
    chk("t2_fault_sticky", 32'(fault), 32'h1);
    chk("t2_stage_reset_sticky", 32'(stage_reset), 32'hF);
    force_lo = 4'b0010;
    sw_pulse(p);
    chk("t2_fault_in_assert", 32'(fault), 32'h1);
    @(negedge clk);
    chk("t2_fault_cleared", 32'(fault), 32'h0);

    // Ready arrives on the would-be timeout edge
    wait_fall(0, p + 1 + HOLD, "t3_fall0", f);
    wait_fall(1, f + 4 + SD, "t3_fall1", f);
    repeat (TO - 1) @(negedge clk);
    force_lo = '0;
    @(negedge clk);
    chk("t3_no_fault", 32'(fault), 32'h0);
    chk("t3_stage_reset", 32'(stage_reset), 32'hC);
    wait_fall(2, f + TO + SD, "t3_fall2", f);
    wait_out(0, -1, "t3_done", f);

    // sw_reset_req on the timeout edge, then premature ready during HOLD
    force_lo = 4'b1000;
    sw_pulse(s);
    wait_fall(0, s + 1 + HOLD, "t6_fall0", f);
    for (int i = 1; i < N; i++) wait_fall(i, f + 4 + SD, "t6_fall", f);
    repeat (TO - 1) @(negedge clk);
    force_lo = '0;
    force_hi = 4'b1000;
    sw_pulse(s);
    chk("t6_sw_vs_timeout_fault", 32'(fault), 32'h0);
    chk("t6_sw_vs_timeout_reset", 32'(stage_reset), 32'hF);
    @(negedge clk);
    chk("t6_fault_after", 32'(fault), 32'h0);
    for (int i = 0; i < N; i++) wait_fall(i, s + 1 + HOLD + i * (4 + SD), "t6_order", f);
    wait_out(0, f + 1, "t6_all_released", f);
    repeat (5) @(negedge clk);
    force_hi = '0;

    // Randomised plant delays, restarts and ready drops
    drop_left = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      reset = 1'b0;
      sw_reset_req = 1'b0;
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) force_lo = '0;
      end
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        reset = 1'b1;
        force_lo = '0;
        drop_left = 0;
        for (int j = 0; j < N; j++) dly[j] = int'($urandom_range(1, 6));
      end else if (r < 5) begin
        sw_reset_req = 1'b1;
      end else if (r < 30 && m_phase == P_RUN && drop_left == 0) begin
        force_lo = N'(1 << $urandom_range(0, N - 1));
        drop_left = int'($urandom_range(1, 2));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    sw_reset_req = 1'b0;
    force_lo = '0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
